// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiplier: operand modes, FSM states
// and mode-to-signedness decode.
package mul_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MUL_UU  = 2'b00,
    MUL_SS  = 2'b01,
    MUL_SU  = 2'b10,
    MUL_RSV = 2'b11
  } mul_mode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  // Reserved mode decodes as unsigned on both operands.
  function automatic logic op1_is_signed(input logic [MODE_W-1:0] m);
    return (m == MUL_SS) || (m == MUL_SU);
  endfunction

  function automatic logic op2_is_signed(input logic [MODE_W-1:0] m);
    return (m == MUL_SS);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One radix step of the iterative multiplier: sum_c = acc + mcand * digit,
// 2*WIDTH wide, carry-out dropped, final add in 4-bit look-ahead groups.
module mul_step #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic [2*WIDTH-1:0]    acc,
  input  logic [2*WIDTH-1:0]    mcand,
  input  logic [RADIX_BITS-1:0] digit,
  output logic [2*WIDTH-1:0]    sum_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned NG = PW / 4;

  logic [PW-1:0] pp;
  logic [PW-1:0] g;
  logic [PW-1:0] p;
  logic [PW-1:0] c;
  logic          gcar;
  logic          grp_g;
  logic          grp_p;

  // Partial product for the current digit; RADIX_BITS is small so this stays shallow.
  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < RADIX_BITS; i++) begin
      if (digit[i]) pp = pp + (mcand << i);
    end
  end

  assign g = acc & pp;
  assign p = acc ^ pp;

  // Nibble-level look-ahead carries chained across groups.
  always_comb begin
    c     = '0;
    gcar  = 1'b0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int unsigned k = 0; k < NG; k++) begin
      c[4*k]   = gcar;
      c[4*k+1] = g[4*k] | (p[4*k] & gcar);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gcar);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gcar);
      grp_g    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p    = &p[4*k +: 4];
      gcar     = grp_g | (grp_p & gcar);
    end
  end

  assign sum_c = p ^ c;

endmodule

// File: rtl/mul_seq.sv
// Iterative signed/unsigned/mixed multiplier behind valid/ready handshakes;
// retires RADIX_BITS multiplier bits per cycle on operand magnitudes, sign fixed at the end.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res
);

  localparam int unsigned N  = WIDTH / RADIX_BITS;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  mul_state_e    state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic [PW-1:0] res_q, res_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic             sgn1_c, sgn2_c;
  logic [WIDTH-1:0] mag1_c, mag2_c;
  logic [PW-1:0]    step_c;

  // Operand sign/magnitude; the most-negative value maps to 2^(WIDTH-1) unsigned.
  assign sgn1_c = op1_is_signed(mode) & op1[WIDTH-1];
  assign sgn2_c = op2_is_signed(mode) & op2[WIDTH-1];
  assign mag1_c = sgn1_c ? (~op1 + WIDTH'(1)) : op1;
  assign mag2_c = sgn2_c ? (~op2 + WIDTH'(1)) : op2;

  mul_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .acc   (acc_q),
    .mcand (mcand_q),
    .digit (mplier_q[RADIX_BITS-1:0]),
    .sum_c (step_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d  = PW'(mag1_c);
          mplier_d = mag2_c;
          // A zero operand never produces a negative result.
          neg_d    = (sgn1_c ^ sgn2_c) & (|op1) & (|op2);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = step_c;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_q >> RADIX_BITS;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        res_d       = neg_q ? (~acc_q + PW'(1)) : acc_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and randomized checks of mul_seq at 32x32 radix-2 and 16x16 radix-16.
module tb_mul_seq;

  logic        clk;
  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_op1, a_op2;
  logic [1:0]  a_mode;
  logic [63:0] a_res;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_op1, b_op2;
  logic [1:0]  b_mode;
  logic [31:0] b_res;

  int n_cmp;
  int n_bad;

  mul_seq #(.WIDTH(32), .RADIX_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op1(a_op1), .op2(a_op2), .mode(a_mode), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .res(a_res)
  );

  mul_seq #(.WIDTH(16), .RADIX_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op1(b_op1), .op2(b_op2), .mode(b_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .res(b_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_op32(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] r, output int lat);
    int n;
    @(negedge clk);
    a_mode = m; a_op1 = x; a_op2 = y; a_in_valid = 1'b1;
    n = 0;
    while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    r = a_res;
    @(negedge clk) a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_out_ready = 1'b0;
  endtask

  task automatic do_op16(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] r, output int lat);
    int n;
    @(negedge clk);
    b_mode = m; b_op1 = x; b_op2 = y; b_in_valid = 1'b1;
    n = 0;
    while (!b_in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r = b_res;
    @(negedge clk) b_out_ready = 1'b1;
    @(posedge clk);
    #1 b_out_ready = 1'b0;
  endtask

  function automatic logic [31:0] ref16(input logic [1:0] m, input logic [15:0] x,
                                        input logic [15:0] y);
    longint sx, sy;
    sx = (m == 2'b01 || m == 2'b10) ? longint'($signed(x)) : longint'(x);
    sy = (m == 2'b01) ? longint'($signed(y)) : longint'(y);
    return 32'(sx * sy);
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_res !== 64'h0) begin n_bad++; $display("FAIL reset_a_res: got %h want 0", a_res); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); end
    n_cmp++; if (b_res !== 32'h0) begin n_bad++; $display("FAIL reset_b_res: got %h want 0", b_res); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_uu();
    logic [63:0] r; int lat;
    do_op32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    n_cmp++; if (r !== 64'hFFFFFFFE00000001) begin n_bad++; $display("FAIL uu_max: got %h want fffffffe00000001", r); end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL uu_latency: got %0d want 33", lat); end
  endtask

  task automatic test_ss();
    logic [63:0] r; int lat;
    do_op32(2'b01, 32'hFFFFFFFF, 32'h00000005, r, lat);
    n_cmp++; if (r !== 64'hFFFFFFFFFFFFFFFB) begin n_bad++; $display("FAIL ss_m1x5: got %h want fffffffffffffffb", r); end
    do_op32(2'b01, 32'h80000000, 32'h80000000, r, lat);
    n_cmp++; if (r !== 64'h4000000000000000) begin n_bad++; $display("FAIL ss_minxmin: got %h want 4000000000000000", r); end
    do_op32(2'b01, 32'h00000005, 32'hFFFFFFFD, r, lat);
    n_cmp++; if (r !== 64'hFFFFFFFFFFFFFFF1) begin n_bad++; $display("FAIL ss_5xm3: got %h want fffffffffffffff1", r); end
    do_op32(2'b01, 32'h00000000, 32'hFFFFFFFB, r, lat);
    n_cmp++; if (r !== 64'h0) begin n_bad++; $display("FAIL ss_zero: got %h want 0", r); end
  endtask

  task automatic test_su_rsv();
    logic [63:0] r; int lat;
    do_op32(2'b10, 32'hFFFFFFFE, 32'hFFFFFFFF, r, lat);
    n_cmp++; if (r !== 64'hFFFFFFFE00000002) begin n_bad++; $display("FAIL su_m2xmax: got %h want fffffffe00000002", r); end
    do_op32(2'b10, 32'h00000000, 32'hFFFFFFFF, r, lat);
    n_cmp++; if (r !== 64'h0) begin n_bad++; $display("FAIL su_zero: got %h want 0", r); end
    do_op32(2'b11, 32'hFFFFFFFF, 32'h00000002, r, lat);
    n_cmp++; if (r !== 64'h00000001FFFFFFFE) begin n_bad++; $display("FAIL rsv_as_uu: got %h want 00000001fffffffe", r); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    a_mode = 2'b00; a_op1 = 32'd5; a_op2 = 32'd3; a_in_valid = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 200) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL bp_latency: got %0d want 33", n); end
    @(negedge clk);
    a_op1 = 32'd4; a_op2 = 32'd4; a_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (a_res !== 64'd15) begin n_bad++; $display("FAIL bp_res_hold: cycle %0d got %h want f", i, a_res); end
      n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_low: cycle %0d got %b want 0", i, a_in_ready); end
      n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid_hold: cycle %0d got %b want 1", i, a_out_valid); end
    end
    @(negedge clk) a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_out_ready = 1'b0;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid: got %b want 0", a_out_valid); end
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_next_accept: got in_ready %b want 0", a_in_ready); end
    n = 0;
    while (!a_out_valid && n < 200) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL bp_next_latency: got %0d want 33", n); end
    n_cmp++; if (a_res !== 64'd16) begin n_bad++; $display("FAIL bp_next_res: got %h want 10", a_res); end
    @(negedge clk) a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; int lat; logic seen;
    @(negedge clk);
    a_mode = 2'b00; a_op1 = 32'h0000FFFF; a_op2 = 32'd3; a_in_valid = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready: got %b want 1", a_in_ready); end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; seen = seen | a_out_valid; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_result: got out_valid %b want 0", seen); end
    do_op32(2'b00, 32'd7, 32'd6, r, lat);
    n_cmp++; if (r !== 64'd42) begin n_bad++; $display("FAIL midreset_next_res: got %h want 2a", r); end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL midreset_next_latency: got %0d want 33", lat); end
  endtask

  task automatic test_radix4();
    logic [31:0] r; int lat;
    do_op16(2'b00, 16'hFFFF, 16'hFFFF, r, lat);
    n_cmp++; if (r !== 32'hFFFE0001) begin n_bad++; $display("FAIL r4_uu_max: got %h want fffe0001", r); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL r4_latency: got %0d want 5", lat); end
    do_op16(2'b01, 16'h8000, 16'h8000, r, lat);
    n_cmp++; if (r !== 32'h40000000) begin n_bad++; $display("FAIL r4_ss_min: got %h want 40000000", r); end
  endtask

  task automatic test_random16();
    logic [31:0] r, e; logic [15:0] x, y; logic [1:0] m; int lat;
    for (int i = 0; i < 1000; i++) begin
      m = 2'($urandom_range(0, 3));
      x = pick16();
      y = pick16();
      e = ref16(m, x, y);
      do_op16(m, x, y, r, lat);
      n_cmp++;
      if (r !== e || lat !== 5) begin
        n_bad++;
        $display("FAIL rand16 #%0d mode %0d %h*%h: got %h lat %0d want %h lat 5", i, m, x, y, r, lat, e);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_op1 = '0; a_op2 = '0; a_mode = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_op1 = '0; b_op2 = '0; b_mode = '0;
    test_reset();
    test_uu();
    test_ss();
    test_su_rsv();
    test_backpressure();
    test_reset_mid();
    test_radix4();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
